// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: program counter, synchronous-read imem requests,
// one-entry skid buffer for decode stalls, and the IF/ID pipeline register.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        valid_out
);

  logic [31:0] pc_next;
  logic        req_v;
  logic [31:0] req_pc;
  logic        skid_v;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;

  // Request issue: a redirect always fetches its target, even under stall.
  always_comb begin
    imem_en   = !reset && (redirect_valid || !stall);
    imem_addr = redirect_valid ? {redirect_pc[31:2], 2'b00} : pc_next;
  end

  // Fetch address and outstanding-request tracking.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_next <= RESET_PC;
      req_v   <= 1'b0;
      req_pc  <= '0;
    end else if (imem_en) begin
      pc_next <= imem_addr + 32'd4;
      req_pc  <= imem_addr;
      req_v   <= 1'b1;
    end else begin
      req_v   <= 1'b0;
    end
  end

  // Skid buffer and IF/ID register; priority is reset > redirect > stall > run.
  // At most one response lands per stall because no request issues while
  // stalled, so a single skid entry is sufficient.
  always_ff @(posedge clock) begin
    if (reset) begin
      skid_v    <= 1'b0;
      skid_inst <= '0;
      skid_pc   <= '0;
      valid_out <= 1'b0;
      inst_out  <= NOP_INST;
      pc_out    <= '0;
    end else if (redirect_valid) begin
      skid_v    <= 1'b0;
      valid_out <= 1'b0;
      inst_out  <= NOP_INST;
    end else if (stall) begin
      if (req_v) begin
        skid_v    <= 1'b1;
        skid_inst <= imem_rdata;
        skid_pc   <= req_pc;
      end
    end else if (skid_v) begin
      skid_v    <= 1'b0;
      valid_out <= 1'b1;
      inst_out  <= skid_inst;
      pc_out    <= skid_pc;
    end else if (req_v) begin
      valid_out <= 1'b1;
      inst_out  <= imem_rdata;
      pc_out    <= req_pc;
    end else begin
      valid_out <= 1'b0;
      inst_out  <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed self-checking bench for instruction_fetch_stage with a
// synchronous-read imem model returning 0x13 + address.
module tb_instruction_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        valid_out;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  instruction_fetch_stage #(
    .RESET_PC(32'h0000_0100),
    .NOP_INST(NOP)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .inst_out       (inst_out),
    .pc_out         (pc_out),
    .valid_out      (valid_out)
  );

  always #5 clock = ~clock;

  // Synchronous-read memory; unrequested cycles return a marker value.
  always @(posedge clock) begin
    imem_rdata <= imem_en ? imem_addr + 32'h13 : 32'hDEAD_BEEF;
  end

  // The skid buffer and an outstanding request must never coexist.
  always @(negedge clock) begin
    if (reset === 1'b0) assert (!(dut.skid_v && dut.req_v));
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; registered outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clock);
    #1;
    check_val("skid_req_exclusive", {31'b0, dut.skid_v & dut.req_v}, 32'h0);
  endtask

  // IF/ID check: a valid entry must carry the instruction matching its PC.
  task automatic expect_out(input string tag, input logic v, input logic [31:0] pc);
    check_val({tag, "_valid"}, {31'b0, valid_out}, {31'b0, v});
    if (v) begin
      check_val({tag, "_pc"}, pc_out, pc);
      check_val({tag, "_inst"}, inst_out, pc + 32'h13);
    end else begin
      check_val({tag, "_nop"}, inst_out, NOP);
    end
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    step();
    step();
    check_val("rst_valid", {31'b0, valid_out}, 32'h0);
    check_val("rst_inst", inst_out, NOP);
    check_val("rst_pc", pc_out, 32'h0);
    check_val("rst_en", {31'b0, imem_en}, 32'h0);

    // Cycle 0: first request is RESET_PC.
    reset = 1'b0;
    #1;
    check_val("c0_en", {31'b0, imem_en}, 32'h1);
    check_val("c0_addr", imem_addr, 32'h100);
    step(); expect_out("c1", 1'b0, 32'h0);
    check_val("c1_addr", imem_addr, 32'h104);
    step(); expect_out("c2", 1'b1, 32'h100);
    step(); expect_out("c3", 1'b1, 32'h104);
    step(); expect_out("c4", 1'b1, 32'h108);
    step(); expect_out("c5", 1'b1, 32'h10C);

    // Single-cycle stall in cycle 5.
    stall = 1'b1;
    #1;
    check_val("c5_stall_en", {31'b0, imem_en}, 32'h0);
    step();
    stall = 1'b0;
    expect_out("c6_hold", 1'b1, 32'h10C);
    check_val("c6_skid", {31'b0, dut.skid_v}, 32'h1);
    step(); expect_out("c7_skid", 1'b1, 32'h110);
    step(); expect_out("c8", 1'b1, 32'h114);
    step(); expect_out("c9", 1'b1, 32'h118);

    // Six-cycle stall, cycles 9..14.
    for (int i = 0; i < 6; i++) begin
      stall = 1'b1;
      #1;
      check_val("long_stall_en", {31'b0, imem_en}, 32'h0);
      step();
      expect_out("long_hold", 1'b1, 32'h118);
      check_val("long_skid", {31'b0, dut.skid_v}, 32'h1);
    end
    stall = 1'b0;
    #1;
    check_val("c15_addr", imem_addr, 32'h120);
    step(); expect_out("c16_skid", 1'b1, 32'h11C);
    step(); expect_out("c17", 1'b1, 32'h120);
    step(); expect_out("c18", 1'b1, 32'h124);

    // Redirect to an unaligned target together with stall.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2003;
    stall = 1'b1;
    #1;
    check_val("redir_en", {31'b0, imem_en}, 32'h1);
    check_val("redir_addr", imem_addr, 32'h2000);
    step();
    redirect_valid = 1'b0;
    stall = 1'b0;
    expect_out("redir_bubble", 1'b0, 32'h0);
    step(); expect_out("redir_t2", 1'b1, 32'h2000);
    step(); expect_out("redir_t3", 1'b1, 32'h2004);

    // Wrap-around at the top of the address space.
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    expect_out("wrap_bubble", 1'b0, 32'h0);
    step(); expect_out("wrap0", 1'b1, 32'hFFFF_FFF8);
    step(); expect_out("wrap1", 1'b1, 32'hFFFF_FFFC);
    step(); expect_out("wrap2", 1'b1, 32'h0000_0000);
    step(); expect_out("wrap3", 1'b1, 32'h0000_0004);

    // Back-to-back redirects: the second one wins.
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    step();
    redirect_pc = 32'h0000_4000;
    expect_out("b2b_bubble0", 1'b0, 32'h0);
    step();
    redirect_valid = 1'b0;
    expect_out("b2b_bubble1", 1'b0, 32'h0);
    step(); expect_out("b2b_t0", 1'b1, 32'h4000);
    step(); expect_out("b2b_t1", 1'b1, 32'h4004);

    // Reset while the skid holds an entry.
    stall = 1'b1;
    step();
    check_val("pre_rst_skid", {31'b0, dut.skid_v}, 32'h1);
    reset = 1'b1;
    step();
    check_val("mid_rst_valid", {31'b0, valid_out}, 32'h0);
    check_val("mid_rst_inst", inst_out, NOP);
    check_val("mid_rst_skid", {31'b0, dut.skid_v}, 32'h0);
    check_val("mid_rst_en", {31'b0, imem_en}, 32'h0);
    reset = 1'b0;
    stall = 1'b0;
    #1;
    check_val("restart_addr", imem_addr, 32'h100);
    step(); expect_out("restart_c1", 1'b0, 32'h0);
    step(); expect_out("restart_c2", 1'b1, 32'h100);
    step(); expect_out("restart_c3", 1'b1, 32'h104);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
